vga_fb_arbiter: RTL and testbench

- Arbitrates one single-port pixel framebuffer memory port between two requesters.
- Requester 1 is the display fetch path (read-only), which feeds the VGA scan-out and has priority.
- Requester 2 is the pattern writer (write-only), which renders test patterns into the framebuffer.
- Burst-limited round-robin between the two bounds writer latency without starving scan-out. Read data returns in order, passed straight through to the display port.

---
 rtl/vga_fb_arbiter.sv | 126 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch (read, priority) vs. pattern writer (write).
// Burst-limited round-robin with a registered grant state and pass-through read data.
module vga_fb_arbiter #(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 12,
    parameter int MAX_RD_BURST = 8,
    parameter int MAX_WR_BURST = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0] wr_cmd_data,

    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [DATA_WIDTH-1:0] mem_cmd_wdata,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [7:0] RD_LIMIT = 8'(MAX_RD_BURST);
    localparam logic [7:0] WR_LIMIT = 8'(MAX_WR_BURST);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;
    logic [7:0] cnt_upd;
    logic [7:0] limit;
    logic       sel_rd;
    logic       sel_wr;
    logic       xfer;

    assign sel_rd = (state_reg == S_RD);
    assign sel_wr = (state_reg == S_WR);

    // Grant mux: only the owning side sees mem_cmd_ready; IDLE presents nothing.
    assign mem_cmd_valid = (sel_rd & rd_cmd_valid) | (sel_wr & wr_cmd_valid);
    assign mem_cmd_we    = sel_wr;
    assign rd_cmd_ready  = sel_rd & mem_cmd_ready;
    assign wr_cmd_ready  = sel_wr & mem_cmd_ready;
    assign xfer          = mem_cmd_valid & mem_cmd_ready;

    // Address follows the reader except during a write grant, so it is always defined.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_mux
            assign mem_cmd_addr[gi] = sel_wr ? wr_cmd_addr[gi] : rd_cmd_addr[gi];
        end
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_wdata_gate
            assign mem_cmd_wdata[gi] = sel_wr & wr_cmd_data[gi];
        end
    endgenerate

    // Responses bypass the grant entirely; only reset masks the strobe.
    assign rd_data_valid = mem_rd_valid & rst_n;
    assign rd_data       = mem_rd_data;

    always_comb begin
        limit      = sel_wr ? WR_LIMIT : RD_LIMIT;
        cnt_upd    = (xfer && (cnt_reg < limit)) ? cnt_reg + 8'd1 : cnt_reg;
        state_next = state_reg;
        cnt_next   = cnt_upd;
        case (state_reg)
            S_IDLE: begin
                cnt_next = 8'd0;
                if (rd_cmd_valid) begin
                    state_next = S_RD;
                end else if (wr_cmd_valid) begin
                    state_next = S_WR;
                end
            end
            S_RD: begin
                // Decision uses the post-beat count so the handover has no bubble.
                if (wr_cmd_valid && (!rd_cmd_valid || (cnt_upd == RD_LIMIT))) begin
                    state_next = S_WR;
                    cnt_next   = 8'd0;
                end else if (!rd_cmd_valid && !wr_cmd_valid) begin
                    state_next = S_IDLE;
                    cnt_next   = 8'd0;
                end
            end
            S_WR: begin
                if (rd_cmd_valid && (!wr_cmd_valid || (cnt_upd == WR_LIMIT))) begin
                    state_next = S_RD;
                    cnt_next   = 8'd0;
                end else if (!rd_cmd_valid && !wr_cmd_valid) begin
                    state_next = S_IDLE;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed phases plus random traffic against an
// ownership/run-length model, a two-cycle memory and an in-order read scoreboard.
module tb_vga_fb_arbiter;

    localparam int AW   = 19;
    localparam int DW   = 12;
    localparam int MAXR = 8;
    localparam int MAXW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_cmd_valid = 1'b0;
    logic          rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr = '0;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          wr_cmd_valid = 1'b0;
    logic          wr_cmd_ready;
    logic [AW-1:0] wr_cmd_addr = '0;
    logic [DW-1:0] wr_cmd_data = '0;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b0;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;

    vga_fb_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_RD_BURST(MAXR),
        .MAX_WR_BURST(MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .wr_cmd_valid (wr_cmd_valid),
        .wr_cmd_ready (wr_cmd_ready),
        .wr_cmd_addr  (wr_cmd_addr),
        .wr_cmd_data  (wr_cmd_data),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we   (mem_cmd_we),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port (0 none, 1 display, 2 writer) and how
    // many beats the owner has moved since it took the port.
    int own = 0;
    int run = 0;

    int checks = 0;
    int passes = 0;
    int obs_rd = 0;
    int obs_wr = 0;
    int obs_wrdy = 0;
    int rd_prob = 0;
    int wr_prob = 0;
    int rdy_prob = 100;
    bit inject = 1'b0;
    bit rx_q = 1'b0;
    bit wx_q = 1'b0;

    logic          p0_v = 1'b0;
    logic          p1_v = 1'b0;
    logic [DW-1:0] p0_d = '0;
    logic [DW-1:0] p1_d = '0;
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive at posedge+1, check and update models at negedge.
    task automatic cycle_body();
        logic [31:0]   r;
        logic [31:0]   r2;
        logic [DW-1:0] exp_d;
        bit            rx;
        bit            wx;
        int            lim;
        int            run_n;

        if (rd_prob == 0) begin
            rd_cmd_valid = 1'b0;
        end else if (!rd_cmd_valid || rx_q) begin
            rd_cmd_valid = ($urandom_range(99) < rd_prob);
            r = $urandom;
            rd_cmd_addr = r[AW-1:0];
        end
        if (wr_prob == 0) begin
            wr_cmd_valid = 1'b0;
        end else if (!wr_cmd_valid || wx_q) begin
            wr_cmd_valid = ($urandom_range(99) < wr_prob);
            r = $urandom;
            r2 = $urandom;
            wr_cmd_addr = r[AW-1:0];
            wr_cmd_data = r2[DW-1:0];
        end
        mem_cmd_ready = ($urandom_range(99) < rdy_prob);
        mem_rd_valid = p1_v;
        mem_rd_data  = p1_d;
        p1_v = p0_v;
        p1_d = p0_d;
        p0_v = 1'b0;
        if (inject) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 12'hABC;
        end

        #4;
        chk("cmd_valid", mem_cmd_valid, (own == 1) ? rd_cmd_valid : (own == 2) ? wr_cmd_valid : 1'b0);
        chk("cmd_we", mem_cmd_we, own == 2);
        chk("cmd_addr", mem_cmd_addr, (own == 2) ? wr_cmd_addr : rd_cmd_addr);
        if (own == 2) chk("cmd_wdata", mem_cmd_wdata, wr_cmd_data);
        chk("rd_ready", rd_cmd_ready, (own == 1) && mem_cmd_ready);
        chk("wr_ready", wr_cmd_ready, (own == 2) && mem_cmd_ready);
        chk("rdata_valid", rd_data_valid, mem_rd_valid);
        if (mem_rd_valid) begin
            if (inject) begin
                exp_d = 12'hABC;
            end else begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                exp_d = (sb.size() != 0) ? sb.pop_front() : '0;
            end
            chk("rd_data", rd_data, exp_d);
        end

        // Memory environment reacts to what the DUT actually issued.
        if (mem_cmd_valid && mem_cmd_ready) begin
            if (mem_cmd_we) begin
                env_mem[mem_cmd_addr[7:0]] = mem_cmd_wdata;
                obs_wr++;
            end else begin
                p0_v = 1'b1;
                p0_d = env_mem[mem_cmd_addr[7:0]];
                obs_rd++;
            end
        end
        if (wr_cmd_ready) obs_wrdy++;

        rx = (own == 1) && rd_cmd_valid && mem_cmd_ready;
        wx = (own == 2) && wr_cmd_valid && mem_cmd_ready;
        if (rx) sb.push_back(ref_mem[rd_cmd_addr[7:0]]);
        if (wx) ref_mem[wr_cmd_addr[7:0]] = wr_cmd_data;
        lim   = (own == 2) ? MAXW : MAXR;
        run_n = (rx || wx) ? ((run + 1 > lim) ? lim : run + 1) : run;
        case (own)
            0: begin
                own = rd_cmd_valid ? 1 : (wr_cmd_valid ? 2 : 0);
                run = 0;
            end
            1: begin
                if (wr_cmd_valid && (!rd_cmd_valid || run_n == MAXR)) begin
                    own = 2; run = 0;
                end else if (!rd_cmd_valid && !wr_cmd_valid) begin
                    own = 0; run = 0;
                end else begin
                    run = run_n;
                end
            end
            default: begin
                if (rd_cmd_valid && (!wr_cmd_valid || run_n == MAXW)) begin
                    own = 1; run = 0;
                end else if (!rd_cmd_valid && !wr_cmd_valid) begin
                    own = 0; run = 0;
                end else begin
                    run = run_n;
                end
            end
        endcase
        rx_q = rx;
        wx_q = wx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_body();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end

        // Reset with both requesters valid and a stray memory strobe.
        rd_prob = 100; wr_prob = 100; rdy_prob = 100;
        rd_cmd_valid = 1'b1; wr_cmd_valid = 1'b1; mem_cmd_ready = 1'b1; mem_rd_valid = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
        chk("rst_rd_ready", rd_cmd_ready, 1'b0);
        chk("rst_wr_ready", wr_cmd_ready, 1'b0);
        chk("rst_rdata_valid", rd_data_valid, 1'b0);
        mem_rd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        own = 0; run = 0;
        cycle_body();
        chk("rel_idle_valid", mem_cmd_valid, 1'b0);
        tick();
        chk("rel_rd_grant", rd_cmd_ready, 1'b1);
        chk("rel_rd_we", mem_cmd_we, 1'b0);

        // Reads only.
        wr_prob = 0; obs_rd = 0; obs_wr = 0; obs_wrdy = 0;
        repeat (50) tick();
        chk("rdonly_reads", obs_rd, 50);
        chk("rdonly_writes", obs_wr, 0);
        chk("rdonly_wr_ready", obs_wrdy, 0);

        // Both continuous from a saturated read burst: 1R, 2W, then 8R/2W blocks.
        wr_prob = 100; obs_rd = 0; obs_wr = 0;
        repeat (40) tick();
        chk("both_writes", obs_wr, 8);
        chk("both_no_bubble", obs_rd + obs_wr, 40);

        // Display drops after three reads while the writer waits.
        rd_prob = 0; wr_prob = 0;
        repeat (2) tick();
        rd_prob = 100; obs_rd = 0;
        tick();
        for (int i = 0; i < 10 && obs_rd < 3; i++) tick();
        chk("drop_three_reads", obs_rd, 3);
        rd_prob = 0; wr_prob = 100;
        tick();
        tick();
        chk("drop_wr_grant", wr_cmd_ready, 1'b1);
        chk("drop_wr_we", mem_cmd_we, 1'b1);
        wr_prob = 0;
        tick();
        tick();
        chk("drop_idle_valid", mem_cmd_valid, 1'b0);

        // Backpressure mid read burst with the writer waiting.
        rd_prob = 100; wr_prob = 100; obs_rd = 0; obs_wr = 0;
        tick();
        for (int i = 0; i < 10 && obs_rd < 3; i++) tick();
        rdy_prob = 0;
        repeat (5) tick();
        chk("stall_reads", obs_rd, 3);
        chk("stall_writes", obs_wr, 0);
        rdy_prob = 100;
        for (int i = 0; i < 30 && obs_wr == 0; i++) tick();
        chk("stall_switch_seen", obs_wr > 0, 1'b1);
        chk("stall_reads_before_write", obs_rd, 8);

        // Memory response arriving during a write grant.
        rd_prob = 0; wr_prob = 100;
        repeat (3) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("inject_valid", rd_data_valid, 1'b1);
        chk("inject_data", rd_data, 12'hABC);
        chk("inject_in_wr", mem_cmd_we, 1'b1);

        // Random traffic, then an asynchronous reset in the middle of a cycle.
        rd_prob = 70; wr_prob = 60; rdy_prob = 75;
        repeat (300) tick();
        @(posedge clk);
        #2;
        mem_rd_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cmd_valid", mem_cmd_valid, 1'b0);
        chk("async_rst_rd_ready", rd_cmd_ready, 1'b0);
        chk("async_rst_wr_ready", wr_cmd_ready, 1'b0);
        chk("async_rst_rdata_valid", rd_data_valid, 1'b0);
        mem_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        own = 0; run = 0;
        cycle_body();
        repeat (100) tick();

        // Drain outstanding reads.
        rd_prob = 0; wr_prob = 0; rdy_prob = 100;
        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
